// File: rtl/mvm_stream_host.sv
// ============================================================================
// Module   : mvm_stream_host
// Brief    : Streams a KxK matrix and K-vector into the MVM engine, collects
//            the K results. Optional MVM_HOST_THROTTLE_EN adds LFSR bubbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvm_stream_host #(
    parameter int K  = 3,
    parameter int AW = $clog2(K*K+K),
    parameter int RW = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 load_we,
    input  logic [AW-1:0]        load_addr,
    input  logic signed [7:0]    load_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic signed [7:0]    tx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic signed [15:0]   rx_data,
    input  logic                 rx_overflow,
    input  logic [RW-1:0]        rd_addr,
    output logic signed [15:0]   rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf_seen
);

    localparam int N = K*K + K;
    localparam logic [AW-1:0] LAST_TX = AW'(N-1);
    localparam logic [RW-1:0] LAST_RX = RW'(K-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [RW-1:0]      rx_cnt_q, rx_cnt_d;
    logic               ovf_q, ovf_d;
    logic signed [7:0]  opbuf_q  [N];
    logic signed [15:0] result_q [K];
    logic               tx_hs, rx_hs;

`ifdef MVM_HOST_THROTTLE_EN
    logic [7:0] lfsr_q;
    logic       hold_q;

    // Once offered, a word stays valid regardless of the LFSR until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
            hold_q <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            hold_q <= tx_valid & ~tx_ready;
        end
    end

    assign tx_valid = (state_q == S_SEND) && (lfsr_q[0] || hold_q);
    assign rx_ready = (state_q == S_RECV) && lfsr_q[0];
`else
    assign tx_valid = (state_q == S_SEND);
    assign rx_ready = (state_q == S_RECV);
`endif

    assign tx_hs    = tx_valid & tx_ready;
    assign rx_hs    = rx_valid & rx_ready;
    assign ovf_seen = ovf_q;

    always_comb begin
        tx_data = '0;
        if (int'(tx_cnt_q) < N) tx_data = opbuf_q[tx_cnt_q];
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < K) rd_data = result_q[rd_addr];
    end

    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SEND;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_SEND: begin
                busy = 1'b1;
                if (tx_hs) begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == LAST_TX) state_d = S_RECV;
                end
            end
            S_RECV: begin
                busy = 1'b1;
                if (rx_hs) begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    ovf_d    = ovf_q | rx_overflow;
                    if (rx_cnt_q == LAST_RX) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < K; i++) result_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            ovf_q    <= ovf_d;
            if (state_q == S_RECV && rx_hs) result_q[rx_cnt_q] <= rx_data;
        end
    end

    // Operand buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_IDLE && load_we && int'(load_addr) < N)
            opbuf_q[load_addr] <= load_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_mvm_stream_host.sv
// ============================================================================
// Module   : tb_mvm_stream_host
// Brief    : Directed self-checking bench for mvm_stream_host (K=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvm_stream_host;

    logic               clk = 1'b0;
    logic               reset, start, load_we;
    logic [3:0]         load_addr;
    logic signed [7:0]  load_data;
    logic               tx_valid, tx_ready;
    logic signed [7:0]  tx_data;
    logic               rx_valid, rx_ready;
    logic signed [15:0] rx_data;
    logic               rx_overflow;
    logic [1:0]         rd_addr;
    logic signed [15:0] rd_data;
    logic               busy, done, ovf_seen;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_word [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3};
    logic [15:0] exp_res  [3]  = '{16'd14, 16'd32, 16'd50};

    mvm_stream_host dut (
        .clk(clk), .reset(reset), .start(start), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_overflow(rx_overflow), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .ovf_seen(ovf_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_results(input string tag, input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
        rd_addr = 2'd0; #1; chk({tag, "_rd0"}, 32'(rd_data), 32'(r0));
        rd_addr = 2'd1; #1; chk({tag, "_rd1"}, 32'(rd_data), 32'(r1));
        rd_addr = 2'd2; #1; chk({tag, "_rd2"}, 32'(rd_data), 32'(r2));
        rd_addr = 2'd3; #1; chk({tag, "_rd3_oor"}, 32'(rd_data), 32'd0);
    endtask

    // Runs one transaction; bp selects backpressure, ovf_idx marks an overflowing
    // result, abort_after>0 resets after that many tx handshakes, inject pokes
    // start/load_we during SEND.
    task automatic run_txn(input bit bp, input int ovf_idx, input int abort_after, input bit inject);
        int         tx_i = 0;
        int         rx_i = 0;
        bit         fin  = 1'b0;
        bit         stall = 1'b0;
        logic [7:0] stall_data = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_send_valid", 32'(tx_valid), 32'd1);
        chk("first_send_ovf_clr", 32'(ovf_seen), 32'd0);
        chk("first_send_busy", 32'(busy), 32'd1);
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            if (abort_after > 0 && tx_i == abort_after) begin
                reset = 1'b1;
                tick();
                chk("abort_tx_valid", 32'(tx_valid), 32'd0);
                chk("abort_rx_ready", 32'(rx_ready), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                tick();
                reset = 1'b0;
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_ovf", 32'(ovf_seen), 32'd0);
                chk_results("abort", 16'd0, 16'd0, 16'd0);
                return;
            end
            if (stall) begin
                chk("stall_valid_hold", 32'(tx_valid), 32'd1);
                chk("stall_data_hold", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && rx_ready) chk("valid_ready_overlap", 32'd1, 32'd0);
            if (done) begin
                fin = 1'b1;
                chk("done_busy_low", 32'(busy), 32'd0);
                if (!bp) chk("done_latency", 32'(cyc), 32'd16);
            end else begin
                tx_ready    = bp ? cyc[0] : 1'b1;
                rx_valid    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                rx_data     = (rx_i < 3) ? exp_res[rx_i] : 16'h0;
                rx_overflow = (rx_i == ovf_idx);
                start       = inject && cyc == 3;
                load_we     = inject && cyc == 3;
                load_addr   = 4'd0;
                load_data   = -8'sd1;
                stall       = tx_valid && !tx_ready;
                stall_data  = tx_data;
                if (tx_valid && tx_ready) begin
                    if (tx_i < 12) chk("tx_word", 32'(tx_data), 32'(exp_word[tx_i]));
                    tx_i++;
                end
                if (rx_valid && rx_ready) rx_i++;
                tick();
                start   = 1'b0;
                load_we = 1'b0;
            end
        end
        rx_valid = 1'b0;
        chk("done_seen", 32'(fin), 32'd1);
        chk("tx_count", 32'(tx_i), 32'd12);
        chk("rx_count", 32'(rx_i), 32'd3);
        tick();
        chk("done_one_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_overflow = 1'b0; rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_rx_ready", 32'(rx_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ovf", 32'(ovf_seen), 32'd0);
        chk_results("reset", 16'd0, 16'd0, 16'd0);

        for (int i = 0; i < 12; i++) begin
            load_we = 1'b1; load_addr = 4'(i); load_data = exp_word[i];
            tick();
        end
        load_we = 1'b0;
        chk("load_visible_word0", 32'(tx_data), 32'd1);

        run_txn(1'b0, -1, 0, 1'b0);
        chk("basic_ovf", 32'(ovf_seen), 32'd0);
        chk_results("basic", 16'd14, 16'd32, 16'd50);

        run_txn(1'b1, -1, 0, 1'b0);
        chk("bp_ovf", 32'(ovf_seen), 32'd0);
        chk_results("bp", 16'd14, 16'd32, 16'd50);

        run_txn(1'b0, 1, 0, 1'b0);
        chk("ovf_after_done", 32'(ovf_seen), 32'd1);
        tick();
        chk("ovf_sticky_idle", 32'(ovf_seen), 32'd1);

        run_txn(1'b0, -1, 0, 1'b1);
        chk("inject_ovf", 32'(ovf_seen), 32'd0);

        run_txn(1'b0, -1, 5, 1'b0);
        chk("post_abort_word0", 32'(tx_data), 32'd1);

        run_txn(1'b0, -1, 0, 1'b0);
        chk_results("final", 16'd14, 16'd32, 16'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
